// File: rtl/updown_sweep_pkg.sv
// Shared definitions for the up/down sweep controller: FSM state encoding
// and default counter width / dwell length.
package updown_sweep_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int DWELL_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UP     = 2'd1,
        ST_DOWN   = 2'd2,
        ST_FINISH = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/updown_sweep_ctrl_sweep_counter.sv
// Up/down counter datapath for the sweep controller. A synchronous load
// has priority over counting. The counter never decides on limits itself;
// the controlling FSM only enables it when a step stays inside the range.
module sweep_counter
    import updown_sweep_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             EN,
    input  logic             U_D,
    output logic [WIDTH-1:0] CNT
);

    logic [WIDTH-1:0] cnt_r;

    // Counter register: load, step up/down when enabled, otherwise hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (LOAD) begin
            cnt_r <= LOAD_VAL;
        end else if (EN) begin
            cnt_r <= U_D ? (cnt_r + WIDTH'(1)) : (cnt_r - WIDTH'(1));
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign CNT = cnt_r;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Up/down sweep controller. On an accepted START it latches the limits,
// mode and direction, then steps the counter between LO and HI, either
// once (single sweep) or back and forth (ping-pong) until STOP.
// Optional build macro UPDOWN_SWEEP_DWELL_EN: when defined, each count
// value is held for DWELL+1 cycles; otherwise the counter steps every cycle.
module updown_sweep_ctrl
    import updown_sweep_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DWELL = DWELL_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic             MODE,
    input  logic             DIR,
    input  logic [WIDTH-1:0] LO,
    input  logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] CNT,
    output logic             U_D,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    sweep_state_e     state_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] hi_r;
    logic             mode_r;
    logic             u_d_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;

    logic             tick_s;
    logic             accept_s;
    logic             reject_s;
    logic             at_lim_s;
    logic             load_s;
    logic [WIDTH-1:0] load_val_s;
    logic             en_s;
    logic [WIDTH-1:0] cnt_s;

`ifdef UPDOWN_SWEEP_DWELL_EN
    localparam int DWELL_W = (DWELL > 0) ? $clog2(DWELL + 1) : 1;

    logic [DWELL_W-1:0] dwell_r;

    // Dwell counter: restarts on load, on every step tick and whenever idle or stopped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dwell_r <= {DWELL_W{1'b0}};
        end else if (load_s || STOP || !busy_r || tick_s) begin
            dwell_r <= {DWELL_W{1'b0}};
        end else begin
            dwell_r <= dwell_r + DWELL_W'(1);
        end
    end

    assign tick_s = (dwell_r == DWELL_W'(DWELL));
`else
    logic dwell_unused_s;

    assign dwell_unused_s = (DWELL != 0);
    assign tick_s         = 1'b1;
`endif

    // Start acceptance, limit detection and counter commands for this cycle.
    always_comb begin
        accept_s   = 1'b0;
        reject_s   = 1'b0;
        at_lim_s   = 1'b0;
        load_s     = 1'b0;
        en_s       = 1'b0;
        load_val_s = DIR ? LO : HI;
        case (state_r)
            ST_IDLE: begin
                if (START && !STOP) begin
                    if (LO <= HI) begin
                        accept_s = 1'b1;
                        load_s   = 1'b1;
                    end else begin
                        reject_s = 1'b1;
                    end
                end else begin
                    accept_s = 1'b0;
                end
            end
            ST_UP: begin
                at_lim_s = (cnt_s == hi_r);
                if (!STOP && tick_s && !at_lim_s) begin
                    en_s = 1'b1;
                end else begin
                    en_s = 1'b0;
                end
            end
            ST_DOWN: begin
                at_lim_s = (cnt_s == lo_r);
                if (!STOP && tick_s && !at_lim_s) begin
                    en_s = 1'b1;
                end else begin
                    en_s = 1'b0;
                end
            end
            default: begin
                en_s = 1'b0;
            end
        endcase
    end

    // Sweep FSM with registered direction, busy, done and error outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            lo_r    <= {WIDTH{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            mode_r  <= 1'b0;
            u_d_r   <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        lo_r    <= LO;
                        hi_r    <= HI;
                        mode_r  <= MODE;
                        u_d_r   <= DIR;
                        busy_r  <= 1'b1;
                        state_r <= DIR ? ST_UP : ST_DOWN;
                    end else if (reject_s) begin
                        err_r <= 1'b1;
                    end
                end
                ST_UP: begin
                    if (STOP) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (tick_s && at_lim_s) begin
                        if (mode_r) begin
                            state_r <= ST_DOWN;
                            u_d_r   <= 1'b0;
                        end else begin
                            state_r <= ST_FINISH;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_DOWN: begin
                    if (STOP) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (tick_s && at_lim_s) begin
                        if (mode_r) begin
                            state_r <= ST_UP;
                            u_d_r   <= 1'b1;
                        end else begin
                            state_r <= ST_FINISH;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_FINISH: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    sweep_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .CLK     (CLK),
        .RST     (RST),
        .LOAD    (load_s),
        .LOAD_VAL(load_val_s),
        .EN      (en_s),
        .U_D     (u_d_r),
        .CNT     (cnt_s)
    );

    assign CNT  = cnt_s;
    assign U_D  = u_d_r;
    assign BUSY = busy_r;
    assign DONE = done_r;
    assign ERR  = err_r;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed testbench for updown_sweep_ctrl with hand-computed expectations.
module tb_updown_sweep_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       STOP = 1'b0;
    logic       MODE = 1'b0;
    logic       DIR = 1'b0;
    logic [3:0] LO = 4'd0;
    logic [3:0] HI = 4'd0;
    logic [3:0] CNT;
    logic       U_D;
    logic       BUSY;
    logic       DONE;
    logic       ERR;

    int checks_r = 0;
    int errors_r = 0;

    updown_sweep_ctrl #(
        .WIDTH(4),
        .DWELL(2)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .START(START),
        .STOP (STOP),
        .MODE (MODE),
        .DIR  (DIR),
        .LO   (LO),
        .HI   (HI),
        .CNT  (CNT),
        .U_D  (U_D),
        .BUSY (BUSY),
        .DONE (DONE),
        .ERR  (ERR)
    );

    always #5 CLK = ~CLK;

    // Single comparison point for every check.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int exp_cnt[8] = '{4, 3, 2, 2, 3, 4, 4, 3};
    int exp_ud[8]  = '{0, 0, 0, 1, 1, 1, 0, 0};

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_cnt", CNT, 0);
        chk("rst_ud", U_D, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        RST = 1'b0;
        tick();

`ifndef UPDOWN_SWEEP_DWELL_EN
        // Single up sweep 3..6, limits changed while busy
        LO = 4'd3; HI = 4'd6; DIR = 1'b1; MODE = 1'b0; START = 1'b1;
        tick();
        START = 1'b0; LO = 4'd0; HI = 4'd15; MODE = 1'b1; DIR = 1'b0;
        chk("up_load_cnt", CNT, 3);
        chk("up_load_busy", BUSY, 1);
        for (int i = 4; i <= 6; i++) begin
            tick();
            chk("up_cnt", CNT, i);
            chk("up_nodone", DONE, 0);
        end
        tick();
        chk("up_done", DONE, 1);
        chk("up_fin_busy", BUSY, 0);
        chk("up_fin_cnt", CNT, 6);
        tick();
        chk("up_done_pulse", DONE, 0);
        chk("up_hold_cnt", CNT, 6);

        // Ping-pong 2..4 starting down, START/limits ignored while busy, then STOP
        LO = 4'd2; HI = 4'd4; DIR = 1'b0; MODE = 1'b1; START = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            LO = 4'd0; HI = 4'd15; MODE = 1'b0; DIR = 1'b1;
            chk("pp_cnt", CNT, exp_cnt[i]);
            chk("pp_ud", U_D, exp_ud[i]);
            chk("pp_busy", BUSY, 1);
        end
        START = 1'b0; STOP = 1'b1;
        tick();
        STOP = 1'b0;
        chk("pp_stop_busy", BUSY, 0);
        chk("pp_stop_cnt", CNT, 3);
        chk("pp_stop_done", DONE, 0);
        tick();
        chk("pp_stop_done2", DONE, 0);
        chk("pp_stop_cnt2", CNT, 3);

        // START with STOP in IDLE does nothing
        LO = 4'd1; HI = 4'd5; DIR = 1'b1; START = 1'b1; STOP = 1'b1;
        tick();
        START = 1'b0; STOP = 1'b0;
        chk("startstop_busy", BUSY, 0);
        chk("startstop_cnt", CNT, 3);
        chk("startstop_err", ERR, 0);

        // Rejected START (LO > HI)
        LO = 4'd9; HI = 4'd5; START = 1'b1;
        tick();
        START = 1'b0;
        chk("rej_err", ERR, 1);
        chk("rej_busy", BUSY, 0);
        chk("rej_cnt", CNT, 3);
        tick();
        chk("rej_err_pulse", ERR, 0);
        chk("rej_busy2", BUSY, 0);

        // LO == HI single sweep
        LO = 4'd7; HI = 4'd7; MODE = 1'b0; DIR = 1'b1; START = 1'b1;
        tick();
        START = 1'b0;
        chk("eq_load_cnt", CNT, 7);
        chk("eq_load_busy", BUSY, 1);
        tick();
        chk("eq_done", DONE, 1);
        chk("eq_cnt", CNT, 7);
        tick();
        chk("eq_done_pulse", DONE, 0);

        // LO == HI ping-pong: U_D toggles every tick
        MODE = 1'b1; START = 1'b1;
        tick();
        START = 1'b0;
        chk("eqpp_ud0", U_D, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("eqpp_ud", U_D, (i % 2 == 0) ? 0 : 1);
            chk("eqpp_cnt", CNT, 7);
            chk("eqpp_busy", BUSY, 1);
        end
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        chk("eqpp_stop_busy", BUSY, 0);
        chk("eqpp_stop_done", DONE, 0);

        // Asynchronous reset mid-sweep (down from 15)
        LO = 4'd0; HI = 4'd15; MODE = 1'b0; DIR = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        repeat (4) tick();
        chk("ar_pre_cnt", CNT, 11);
        chk("ar_pre_ud", U_D, 0);
        #2;
        RST = 1'b1;
        #1;
        chk("ar_cnt", CNT, 0);
        chk("ar_ud", U_D, 1);
        chk("ar_busy", BUSY, 0);
        chk("ar_done", DONE, 0);
        #1;
        RST = 1'b0;
        tick();
        chk("ar_idle_busy", BUSY, 0);
        LO = 4'd1; HI = 4'd2; DIR = 1'b1; MODE = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        chk("ar_restart_cnt", CNT, 1);
        chk("ar_restart_busy", BUSY, 1);
        tick();
        chk("ar_restart_cnt2", CNT, 2);
        tick();
        chk("ar_restart_done", DONE, 1);
`else
        // Dwell of 3 cycles per value, 0..2 single sweep
        LO = 4'd0; HI = 4'd2; DIR = 1'b1; MODE = 1'b0; START = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            START = 1'b0;
            chk("dw_cnt", CNT, i / 3);
            chk("dw_busy", BUSY, 1);
            chk("dw_nodone", DONE, 0);
        end
        tick();
        chk("dw_done", DONE, 1);
        chk("dw_fin_cnt", CNT, 2);
        tick();
        chk("dw_done_pulse", DONE, 0);

        // STOP in the middle of a dwell
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        chk("dw_stop_busy", BUSY, 0);
        chk("dw_stop_cnt", CNT, 0);
        chk("dw_stop_done", DONE, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
